// File: rtl/clk_enable_gen_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package clk_enable_gen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Widest channel index and ratio a config write can carry (ACC_WIDTH <= 32)
    localparam int CFG_CHAN_W = 8;
    localparam int CFG_VAL_W  = 32;

    typedef struct packed {
        logic [CFG_CHAN_W-1:0] chan;
        logic [CFG_VAL_W-1:0]  num;
        logic [CFG_VAL_W-1:0]  den;
    } cfg_t;

    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int CNT_W = cnt_width(1024);

    function automatic logic cfg_is_valid(input cfg_t c, input int num_channels);
        return (c.den != '0) && (c.num <= c.den) && (int'(c.chan) < num_channels);
    endfunction

endpackage

// File: rtl/clk_enable_gen_frac_div.sv
// One fractional-rate enable channel: num pulses every den clocks, with a
// shadowed ratio that switches over on a pulse boundary.
module frac_div_chan #(
    parameter int                   ACC_WIDTH   = 16,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_NUM = 1,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_DEN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 sync,
    input  logic                 load_shadow,
    input  logic [ACC_WIDTH-1:0] num,
    input  logic [ACC_WIDTH-1:0] den,
    output logic                 cen,
    output logic                 pending
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] num_act;
    logic [ACC_WIDTH-1:0] den_act;
    logic [ACC_WIDTH-1:0] num_shd;
    logic [ACC_WIDTH-1:0] den_shd;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] diff;
    logic                 hit;
    logic                 apply;

    always_comb begin
        sum   = {1'b0, acc} + {1'b0, num_act};
        diff  = ACC_WIDTH'(sum - {1'b0, den_act});
        hit   = (sum >= {1'b0, den_act});
        // Switching on a pulse edge keeps the phase; a restart or idle channel has no phase to keep
        apply = pending && (!run || sync || (num_act == '0) || hit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            cen     <= 1'b0;
            num_act <= DEFAULT_NUM;
            den_act <= DEFAULT_DEN;
            num_shd <= DEFAULT_NUM;
            den_shd <= DEFAULT_DEN;
            pending <= 1'b0;
        end else begin
            if (!run || sync) begin
                acc <= '0;
                cen <= 1'b0;
            end else begin
                acc <= hit ? diff : sum[ACC_WIDTH-1:0];
                cen <= hit;
            end

            if (apply) begin
                num_act <= num_shd;
                den_act <= den_shd;
                pending <= 1'b0;
            end else if (load_shadow) begin
                num_shd <= num;
                den_shd <= den;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_enable_gen.sv
// PLL-lock sequencer plus NUM_CHANNELS programmable fractional clock enables,
// all running on the single fast PLL clock.
module clk_enable_gen
    import clk_enable_gen_pkg::*;
#(
    parameter int                              NUM_CHANNELS = 2,
    parameter int                              ACC_WIDTH    = 16,
    parameter int                              LOCK_CYCLES  = 1024,
    parameter int                              SYNC_STAGES  = 2,
    parameter logic [NUM_CHANNELS*ACC_WIDTH-1:0] DEFAULT_NUM = {16'd1, 16'd1},
    parameter logic [NUM_CHANNELS*ACC_WIDTH-1:0] DEFAULT_DEN = {16'd3, 16'd1},
    localparam int                             CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic                    sync,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CHAN_W-1:0]       cfg_chan,
    input  logic [ACC_WIDTH-1:0]    cfg_num,
    input  logic [ACC_WIDTH-1:0]    cfg_den,
    output logic                    cfg_err,
    output logic [NUM_CHANNELS-1:0] cen,
    output logic                    locked,
    output logic                    rst_out_n
);

    localparam int LCW = (cnt_width(LOCK_CYCLES) > CNT_W) ? cnt_width(LOCK_CYCLES) : CNT_W;
    localparam logic [LCW-1:0] CNT_LAST = LCW'(LOCK_CYCLES - 1);

    logic [SYNC_STAGES-1:0]  lk_sync;
    logic                    lk;
    state_t                  state;
    state_t                  state_nxt;
    logic [LCW-1:0]          cnt;
    logic [LCW-1:0]          cnt_nxt;
    logic                    run;
    logic                    chan_restart;
    logic                    cfg_open;
    logic                    cfg_fire;
    logic                    cfg_ok;
    cfg_t                    req;
    logic [NUM_CHANNELS-1:0] load_vec;
    logic [NUM_CHANNELS-1:0] pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lk_sync <= '0;
        end else begin
            lk_sync[0] <= pll_locked;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                lk_sync[i] <= lk_sync[i-1];
            end
        end
    end

    assign lk = lk_sync[SYNC_STAGES-1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            WAIT_LOCK: begin
                if (lk) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lk) begin
                    state_nxt = WAIT_LOCK;
                end
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    // Outputs follow the next state so locked and the enables drop on the same edge
    assign run          = (state_nxt == RUN);
    assign chan_restart = run && (sync || (state != RUN));

    always_comb begin
        req      = '0;
        req.chan = CFG_CHAN_W'(cfg_chan);
        req.num  = CFG_VAL_W'(cfg_num);
        req.den  = CFG_VAL_W'(cfg_den);
    end

    assign cfg_ready = cfg_open && !(|pending);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_ok    = cfg_is_valid(req, NUM_CHANNELS);

    always_comb begin
        load_vec = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            load_vec[c] = cfg_fire && cfg_ok && (int'(req.chan) == c);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            locked    <= 1'b0;
            rst_out_n <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_open  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            locked    <= run;
            rst_out_n <= run;
            cfg_err   <= cfg_fire && !cfg_ok;
            cfg_open  <= 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        frac_div_chan #(
            .ACC_WIDTH   (ACC_WIDTH),
            .DEFAULT_NUM (DEFAULT_NUM[c*ACC_WIDTH +: ACC_WIDTH]),
            .DEFAULT_DEN (DEFAULT_DEN[c*ACC_WIDTH +: ACC_WIDTH])
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .run         (run),
            .sync        (chan_restart),
            .load_shadow (load_vec[c]),
            .num         (cfg_num),
            .den         (cfg_den),
            .cen         (cen[c]),
            .pending     (pending[c])
        );
    end

endmodule
